// File: rtl/pulse_stretcher.sv
// ---------------------------------------------------------------------------
// pulse_stretcher
//
// Turns single-cycle event pulses into a visible level waveform.
// Each accepted event gives a high window of exactly HIGH_CYCLES clocks.
// A low guard gap of GAP_CYCLES clocks follows each window.
// Events that arrive while a window or gap is running are queued in a
// saturating pending counter. They are replayed back to back.
//
// Parameters:
//   HIGH_CYCLES - length of each high window in clk cycles (>= 1)
//   GAP_CYCLES  - low guard time after each window in clk cycles (>= 0);
//                 0 removes the gap state entirely
//   PEND_W      - width of the pending counter; queue depth is 2**PEND_W-1
//
// Ports:
//   clk         - system clock
//   reset       - asynchronous, active-high reset
//   pulse_in    - event request; every high cycle counts as one event
//   clr         - synchronous abort: drops the window, queue and overflow
//   level_out   - stretched output level (registered)
//   busy        - high while a window or gap is running (registered)
//   pending_cnt - number of queued events not yet started
//   overflow    - sticky: an event was dropped because the queue was full
// ---------------------------------------------------------------------------
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 12_500_000,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse_in,
  input  logic              clr,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending_cnt,
  output logic              overflow
);

  // The down-counter is shared by the HIGH and GAP phases. It is sized for
  // the longer of the two phases.
  localparam int MAX_CYCLES = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam bit HAS_GAP    = (GAP_CYCLES > 0);

  // The counter is loaded with length-1 and the phase ends when it reads 0.
  // A phase of N cycles therefore spans exactly N clocks.
  localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              level_reg;
  logic              busy_reg;
  logic [PEND_W-1:0] pend_reg;
  logic              ovf_reg;

  logic              cnt_zero;
  logic              win_end;
  logic              restart;
  logic [PEND_W-1:0] pend_next;
  logic              ovf_next;

  assign cnt_zero = (cnt_reg == '0);

  // Window end: this is the last cycle of the gap.
  // When there is no gap state, it is the last cycle of the high window.
  assign win_end = cnt_zero &&
                   ((state_reg == S_GAP) || ((state_reg == S_HIGH) && !HAS_GAP));

  // At window end a new window starts if there is a queued event.
  // It also starts if an event arrives in that same cycle.
  assign restart = (pend_reg != '0) || pulse_in;

  // Pending queue bookkeeping.
  // At window end a queued event is consumed.
  // If a pulse arrives in that same cycle, it takes the freed slot and the
  // count is unchanged. This case never overflows.
  // With an empty queue, a pulse at window end is consumed directly and
  // never touches the counter.
  // Outside window end, every pulse is queued until the counter saturates.
  always_comb begin
    pend_next = pend_reg;
    ovf_next  = ovf_reg;
    if (state_reg != S_IDLE) begin
      if (win_end) begin
        if ((pend_reg != '0) && !pulse_in) begin
          pend_next = pend_reg - 1'b1;
        end
      end else if (pulse_in) begin
        if (pend_reg == PEND_MAX) begin
          ovf_next = 1'b1;
        end else begin
          pend_next = pend_reg + 1'b1;
        end
      end
    end
  end

  // Main FSM. Outputs are computed from the next state, so level_out and busy
  // come straight from flops and are valid in the cycle they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      busy_reg  <= 1'b0;
      pend_reg  <= '0;
      ovf_reg   <= 1'b0;
    end else if (clr) begin
      // Abort: any pulse in this cycle is discarded.
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      busy_reg  <= 1'b0;
      pend_reg  <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      pend_reg <= pend_next;
      ovf_reg  <= ovf_next;
      case (state_reg)
        S_IDLE: begin
          if (pulse_in) begin
            state_reg <= S_HIGH;
            cnt_reg   <= HIGH_LOAD;
            level_reg <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end

        S_HIGH, S_GAP: begin
          if (win_end) begin
            if (restart) begin
              // The next window starts immediately after the gap.
              // No idle cycle is inserted in between.
              state_reg <= S_HIGH;
              cnt_reg   <= HIGH_LOAD;
              level_reg <= 1'b1;
              busy_reg  <= 1'b1;
            end else begin
              state_reg <= S_IDLE;
              cnt_reg   <= '0;
              level_reg <= 1'b0;
              busy_reg  <= 1'b0;
            end
          end else if (cnt_zero) begin
            // Only reached at the end of HIGH when a gap exists.
            state_reg <= S_GAP;
            cnt_reg   <= GAP_LOAD;
            level_reg <= 1'b0;
            busy_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        default: begin
          state_reg <= S_IDLE;
          cnt_reg   <= '0;
          level_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign level_out   = level_reg;
  assign busy        = busy_reg;
  assign pending_cnt = pend_reg;
  assign overflow    = ovf_reg;

endmodule

// File: tb/tb_pulse_stretcher.sv
// ---------------------------------------------------------------------------
// tb_pulse_stretcher
//
// Directed, table-driven bench for pulse_stretcher.
// Configuration: HIGH_CYCLES=4, GAP_CYCLES=2, PEND_W=2.
//
// Each table row gives the inputs driven for one clock cycle.
// It also gives the outputs expected in the following cycle.
// Outputs are sampled 1 time unit after the rising edge.
// The asynchronous reset cases are written out by hand.
// ---------------------------------------------------------------------------
module tb_pulse_stretcher;

  localparam int HIGH_CYCLES = 4;
  localparam int GAP_CYCLES  = 2;
  localparam int PEND_W      = 2;

  logic              clk;
  logic              reset;
  logic              pulse_in;
  logic              clr;
  logic              level_out;
  logic              busy;
  logic [PEND_W-1:0] pending_cnt;
  logic              overflow;

  pulse_stretcher #(
    .HIGH_CYCLES(HIGH_CYCLES),
    .GAP_CYCLES (GAP_CYCLES),
    .PEND_W     (PEND_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pulse_in   (pulse_in),
    .clr        (clr),
    .level_out  (level_out),
    .busy       (busy),
    .pending_cnt(pending_cnt),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              pulse;
    logic              clr;
    logic              level;
    logic              busy;
    logic [PEND_W-1:0] pend;
    logic              ovf;
  } vec_t;

  vec_t vecs[$];
  int   total_checks;
  int   passed_checks;

  // Appends n identical rows.
  task automatic add_n(input int n, input logic p, input logic c, input logic l,
                       input logic b, input logic [PEND_W-1:0] pd, input logic o);
    vec_t v;
    v.pulse = p;
    v.clr   = c;
    v.level = l;
    v.busy  = b;
    v.pend  = pd;
    v.ovf   = o;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic l, input logic b,
                       input logic [PEND_W-1:0] pd, input logic o);
    total_checks++;
    if ({level_out, busy, pending_cnt, overflow} !== {l, b, pd, o}) begin
      $display("FAIL %s: got level=%0b busy=%0b pend=%0d ovf=%0b, expected level=%0b busy=%0b pend=%0d ovf=%0b",
               name, level_out, busy, pending_cnt, overflow, l, b, pd, o);
    end else begin
      passed_checks++;
    end
  endtask

  task automatic tick(input logic p, input logic c);
    pulse_in = p;
    clr      = c;
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    reset    = 1'b0;
    pulse_in = 1'b0;
    clr      = 1'b0;

    // --- Async reset with no clock edge ---
    #2 reset = 1'b1;
    #1;
    check("reset_async_t3", 1'b0, 1'b0, 2'd0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    tick(1'b0, 1'b0);
    check("reset_release_hold", 1'b0, 1'b0, 2'd0, 1'b0);

    // --- Build the vector table (pulse, clr, exp level, busy, pend, ovf) ---
    // Single pulse
    add_n(1, 1, 0, 1, 1, 0, 0);
    add_n(3, 0, 0, 1, 1, 0, 0);
    add_n(2, 0, 0, 0, 1, 0, 0);
    add_n(1, 0, 0, 0, 0, 0, 0);
    // Pulse at N, plus pulses at N+2 and N+3: three windows
    add_n(1, 1, 0, 1, 1, 0, 0);
    add_n(1, 0, 0, 1, 1, 0, 0);
    add_n(1, 1, 0, 1, 1, 1, 0);
    add_n(1, 1, 0, 1, 1, 2, 0);
    add_n(2, 0, 0, 0, 1, 2, 0);
    add_n(4, 0, 0, 1, 1, 1, 0);
    add_n(2, 0, 0, 0, 1, 1, 0);
    add_n(4, 0, 0, 1, 1, 0, 0);
    add_n(2, 0, 0, 0, 1, 0, 0);
    add_n(1, 0, 0, 0, 0, 0, 0);
    // Overflow: pulses at N..N+4
    add_n(1, 1, 0, 1, 1, 0, 0);
    add_n(1, 1, 0, 1, 1, 1, 0);
    add_n(1, 1, 0, 1, 1, 2, 0);
    add_n(1, 1, 0, 1, 1, 3, 0);
    add_n(1, 1, 0, 0, 1, 3, 1);
    add_n(1, 0, 0, 0, 1, 3, 1);
    add_n(4, 0, 0, 1, 1, 2, 1);
    add_n(2, 0, 0, 0, 1, 2, 1);
    add_n(4, 0, 0, 1, 1, 1, 1);
    add_n(2, 0, 0, 0, 1, 1, 1);
    add_n(4, 0, 0, 1, 1, 0, 1);
    add_n(2, 0, 0, 0, 1, 0, 1);
    add_n(3, 0, 0, 0, 0, 0, 1);
    // clr with a simultaneous pulse: pulse discarded, overflow cleared
    add_n(1, 1, 1, 0, 0, 0, 0);
    add_n(1, 0, 0, 0, 0, 0, 0);
    // Back-to-back direct start on the last gap cycle
    add_n(1, 1, 0, 1, 1, 0, 0);
    add_n(3, 0, 0, 1, 1, 0, 0);
    add_n(2, 0, 0, 0, 1, 0, 0);
    add_n(1, 1, 0, 1, 1, 0, 0);
    add_n(3, 0, 0, 1, 1, 0, 0);
    add_n(2, 0, 0, 0, 1, 0, 0);
    add_n(1, 0, 0, 0, 0, 0, 0);
    // Full queue plus a pulse at window end: no overflow; then clr mid-window
    add_n(1, 1, 0, 1, 1, 0, 0);
    add_n(1, 1, 0, 1, 1, 1, 0);
    add_n(1, 1, 0, 1, 1, 2, 0);
    add_n(1, 1, 0, 1, 1, 3, 0);
    add_n(2, 0, 0, 0, 1, 3, 0);
    add_n(1, 1, 0, 1, 1, 3, 0);
    add_n(1, 0, 1, 0, 0, 0, 0);
    add_n(1, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      tick(vecs[i].pulse, vecs[i].clr);
      $display("vec %0d: pulse=%0b clr=%0b -> level=%0b busy=%0b pend=%0d ovf=%0b",
               i, vecs[i].pulse, vecs[i].clr, level_out, busy, pending_cnt, overflow);
      check($sformatf("vec%0d", i), vecs[i].level, vecs[i].busy, vecs[i].pend, vecs[i].ovf);
    end

    // --- Async reset mid-GAP with queued events ---
    tick(1'b1, 1'b0);   // N+1: HIGH
    tick(1'b1, 1'b0);   // N+2: pend 1
    tick(1'b1, 1'b0);   // N+3: pend 2
    tick(1'b0, 1'b0);   // N+4
    tick(1'b0, 1'b0);   // N+5: first GAP cycle
    check("pre_reset_gap", 1'b0, 1'b1, 2'd2, 1'b0);
    reset = 1'b1;
    #1;
    check("reset_mid_gap", 1'b0, 1'b0, 2'd0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick(1'b0, 1'b0);
    check("after_reset_idle", 1'b0, 1'b0, 2'd0, 1'b0);
    tick(1'b0, 1'b0);
    check("queue_lost_idle", 1'b0, 1'b0, 2'd0, 1'b0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts single-cycle event pulses, as produced by the team's edge detectors, into a visible level waveform for LEDs, buzzers or GPIO outputs.
- Each accepted event produces a high window of exactly HIGH_CYCLES cycles, followed by a low guard gap of GAP_CYCLES cycles.
- Events that arrive while a window or gap is running are queued in a saturating pending counter, so no event is lost up to the queue depth.

Parameters:
- HIGH_CYCLES, 25_000_000, length of each high window in clk cycles; must be >= 1.
- GAP_CYCLES, 12_500_000, minimum low time after each window in clk cycles; must be >= 0; 0 means no gap state.
- PEND_W, 4, width of the pending counter; maximum queued events = 2**PEND_W-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- pulse_in  input  1  single-cycle event request; sampled every cycle; each high cycle counts as one event.
- clr  input  1  synchronous abort/clear.
- level_out  output  1  stretched output level; registered.
- busy  output  1  high while in HIGH or GAP; registered.
- pending_cnt  output  PEND_W  number of queued, not-yet-started events.
- overflow  output  1  sticky flag: at least one event was dropped because the queue was full.

Behaviour:
- Reset (async, active-high): state=IDLE, internal counter=0, level_out=0, busy=0, pending_cnt=0, overflow=0.
- FSM states: IDLE, HIGH, GAP. Down-counter width = $clog2(max(HIGH_CYCLES,GAP_CYCLES)+1).
- IDLE: level_out=0, busy=0, pending_cnt is always 0 here.
  - pulse_in=1 -> HIGH next cycle. Latency: level_out=1 on the cycle after pulse_in.
- HIGH: level_out=1 for exactly HIGH_CYCLES consecutive cycles.
  - Then GAP if GAP_CYCLES>0; otherwise apply the "window end" decision below directly.
- GAP: level_out=0, busy=1 for exactly GAP_CYCLES cycles, then apply the window end decision.
- Window end decision, evaluated on the last cycle of GAP (or of HIGH when GAP_CYCLES=0):
  - pending_cnt>0 -> next state HIGH; pending_cnt decrements by 1.
  - Else if pulse_in=1 -> HIGH; the pulse is consumed directly and pending_cnt stays 0.
  - Else -> IDLE.
  - In every case, level_out is contiguous low->high with no extra idle cycle.
- pulse_in in HIGH or GAP (not consumed at window end): pending_cnt += 1.
  - If already at 2**PEND_W-1, the count stays saturated, the event is dropped, and overflow is set to 1.
- Simultaneous pulse_in and decrement at window end: the arrival is queued and the start consumes one, so pending_cnt is unchanged. This does not overflow even when pending_cnt is full.
- overflow stays set until clr or reset.
- clr=1 (synchronous, highest priority after reset): next cycle state=IDLE, level_out=0, busy=0, pending_cnt=0, overflow=0. A pulse_in in the same cycle is discarded.
- Reset mid-window: immediate return to reset values; queued events are lost.
- level_out and busy come directly from flops; no combinational path from pulse_in to outputs.

Test Plan:
All scenarios use HIGH_CYCLES=4, GAP_CYCLES=2, PEND_W=2.
1. Reset: assert reset with clk running -> level_out=0, busy=0, pending_cnt=0, overflow=0 immediately, without waiting for a clk edge. Deassert -> outputs hold 0.
2. Single pulse_in at cycle N:
   - level_out=1 at cycles N+1..N+4 and 0 at N+5, N+6.
   - busy=1 at N+1..N+6 and busy=0 at N+7.
3. Pulse at N, plus pulses at N+2 and N+3:
   - pending_cnt=1 then 2.
   - level_out high N+1..N+4, N+7..N+10 and N+13..N+16.
   - pending_cnt=1 at N+7 and 0 at N+13; busy drops at N+19.
4. Overflow: pulse at N, then 4 pulses at N+1..N+4 -> pending_cnt saturates at 3 and overflow=1 from N+5.
   - Three further windows follow; overflow stays 1 after return to IDLE.
5. Back-to-back direct start: single pulse at N, second pulse at N+6 (last GAP cycle) with pending_cnt=0:
   - level_out high again N+7..N+10, with no IDLE cycle; pending_cnt stays 0.
6. Abort paths:
   - clr at N+2 with pending_cnt=2 and overflow=1 -> at N+3 level_out=0, busy=0, pending_cnt=0, overflow=0. A pulse_in simultaneous with clr is ignored.
   - Async reset mid-GAP -> same zeros with no clk edge needed.
